// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Shared constants for the writeback-side register file:
//               default widths, zero word, nop register address and the
//               reset / write / read enable encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [DEF_ADDR_W-1:0] NOP_REG   = '0;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

endpackage : wb_regfile_pkg
`default_nettype wire

// File: rtl/wb_regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_rdport
// Description : One asynchronous read port of the register file. Resolves,
//               in priority order: reset, port disable, hardwired-zero
//               register, same-cycle writeback bypass, stored array value.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_rdport
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wb_exist,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] arr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  // Priority mux: reset and zero cases dominate the bypass so decode never
  // sees a pending write to the hardwired-zero register.
  always_comb begin
    rd_data = '0;
    if (rst == RST_ENABLE) begin
      rd_data = '0;
    end else if (rd_en == READ_DISABLE) begin
      rd_data = '0;
    end else if (rd_addr == ZERO_IDX) begin
      rd_data = '0;
    end else if ((wb_exist == WRITE_ENABLE) && (wb_addr == rd_addr)) begin
      rd_data = wb_data;
    end else begin
      rd_data = arr_data;
    end
  end

endmodule : wb_regfile_rdport
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : General-purpose register file at the end of the writeback
//               path. One synchronous write port, two combinational read
//               ports with same-cycle bypass, hardwired-zero register and a
//               wrapping count of committed writes.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_des_exist,
  input  logic [ADDR_W-1:0] wb_des_addr,
  input  logic [DATA_W-1:0] wb_des_data,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic [15:0]       wr_count
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_commit;

  // A write only lands when it targets a real (non-zero) register.
  assign wr_commit = (wb_des_exist == WRITE_ENABLE) && (wb_des_addr != ZERO_IDX);

  // Storage: reset clears every entry so unwritten registers never read X;
  // reset also wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[wb_des_addr] <= wb_des_data;
    end
  end

  // Committed-write counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_count <= '0;
    end else if (wr_commit) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  wb_regfile_rdport #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rdport1 (
    .rst      (rst),
    .rd_en    (rd1_en),
    .rd_addr  (rd1_addr),
    .wb_exist (wb_des_exist),
    .wb_addr  (wb_des_addr),
    .wb_data  (wb_des_data),
    .arr_data (regs[rd1_addr]),
    .rd_data  (rd1_data)
  );

  wb_regfile_rdport #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rdport2 (
    .rst      (rst),
    .rd_en    (rd2_en),
    .rd_addr  (rd2_addr),
    .wb_exist (wb_des_exist),
    .wb_addr  (wb_des_addr),
    .wb_data  (wb_des_data),
    .arr_data (regs[rd2_addr]),
    .rd_data  (rd2_data)
  );

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile. A behavioural register
//               file model is compared against the DUT every cycle; directed
//               vectors also carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        wb_des_exist;
  logic [4:0]  wb_des_addr;
  logic [31:0] wb_des_data;
  logic        rd1_en;
  logic [4:0]  rd1_addr;
  logic [31:0] rd1_data;
  logic        rd2_en;
  logic [4:0]  rd2_addr;
  logic [31:0] rd2_data;
  logic [15:0] wr_count;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Reference state
  logic [31:0] m_mem [32];
  logic [15:0] m_cnt;

  wb_regfile #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NREG     (32),
    .ZERO_REG (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_des_exist (wb_des_exist),
    .wb_des_addr  (wb_des_addr),
    .wb_des_data  (wb_des_data),
    .rd1_en       (rd1_en),
    .rd1_addr     (rd1_addr),
    .rd1_data     (rd1_data),
    .rd2_en       (rd2_en),
    .rd2_addr     (rd2_addr),
    .rd2_data     (rd2_data),
    .wr_count     (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // What a read port must return, straight from the architectural rules.
  function automatic logic [31:0] model_read(input logic en, input logic [4:0] a);
    if (rst) return 32'h0;
    if (!en) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (wb_des_exist && wb_des_addr == a) return wb_des_data;
    return m_mem[a];
  endfunction

  // Model state update on each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_cnt = 16'h0;
    end else if (wb_des_exist && wb_des_addr != 5'd0) begin
      m_mem[wb_des_addr] = wb_des_data;
      m_cnt = m_cnt + 16'h1;
    end
  end

  // Cycle-by-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_rd1", rd1_data, model_read(rd1_en, rd1_addr));
      check("cyc_rd2", rd2_data, model_read(rd2_en, rd2_addr));
      check("cyc_wr_count", {16'h0, wr_count}, {16'h0, m_cnt});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic ex, input logic [4:0] a, input logic [31:0] d);
    wb_des_exist = ex;
    wb_des_addr  = a;
    wb_des_data  = d;
  endtask

  task automatic set_rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    rd1_en   = e1;
    rd1_addr = a1;
    rd2_en   = e2;
    rd2_addr = a2;
  endtask

  initial begin
    rst = 1'b1;
    set_wr(1'b1, 5'd3, 32'hDEADBEEF);
    set_rd(1'b1, 5'd3, 1'b1, 5'd3);

    // Reset held two cycles with a write presented
    step();
    chk_on = 1'b1;
    #2 check("rst_rd1_during", rd1_data, 32'h0);
    check("rst_rd2_during", rd2_data, 32'h0);
    step();
    rst = 1'b0;
    set_wr(1'b0, 5'd3, 32'hDEADBEEF);
    #2 check("rst_rd1_after", rd1_data, 32'h0);
    check("rst_wr_count", {16'h0, wr_count}, 32'h0);

    // Write then read
    set_wr(1'b1, 5'd5, 32'h12345678);
    set_rd(1'b0, 5'd0, 1'b0, 5'd0);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 5'd5, 1'b1, 5'd5);
    #2 check("wr_rd1", rd1_data, 32'h12345678);
    check("wr_rd2", rd2_data, 32'h12345678);
    check("wr_count1", {16'h0, wr_count}, 32'd1);

    // Bypass on r7
    set_wr(1'b1, 5'd7, 32'h1);
    step();
    set_wr(1'b1, 5'd7, 32'hAAAA5555);
    set_rd(1'b1, 5'd7, 1'b1, 5'd5);
    #2 check("byp_rd1", rd1_data, 32'hAAAA5555);
    check("byp_rd2_other", rd2_data, 32'h12345678);
    step();
    set_wr(1'b0, 5'd7, 32'h0);
    set_rd(1'b1, 5'd7, 1'b1, 5'd7);
    #2 check("byp_array_rd1", rd1_data, 32'hAAAA5555);
    check("byp_array_rd2", rd2_data, 32'hAAAA5555);
    check("byp_wr_count", {16'h0, wr_count}, 32'd3);

    // Zero register: write and read r0 in the same cycle
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(1'b1, 5'd0, 1'b1, 5'd0);
    #2 check("zero_rd1_byp", rd1_data, 32'h0);
    check("zero_rd2_byp", rd2_data, 32'h0);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    #2 check("zero_rd1_later", rd1_data, 32'h0);
    check("zero_wr_count", {16'h0, wr_count}, 32'd3);

    // Enable gating
    set_wr(1'b1, 5'd9, 32'h55);
    step();
    set_wr(1'b0, 5'd9, 32'h77);
    set_rd(1'b1, 5'd9, 1'b0, 5'd9);
    #2 check("gate_rd2_dis", rd2_data, 32'h0);
    check("gate_rd1_nobyp", rd1_data, 32'h55);
    step();
    set_rd(1'b1, 5'd9, 1'b1, 5'd9);
    #2 check("gate_r9_kept", rd2_data, 32'h55);
    check("gate_wr_count", {16'h0, wr_count}, 32'd4);

    // Counter wrap: clear, 65535 writes, then one more
    rst = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      set_wr(1'b1, 5'((i % 31) + 1), 32'(i));
      step();
    end
    set_wr(1'b0, 5'd0, 32'h0);
    // last write i=65534 -> r((65534%31)+1)=r1, data 0xFFFE
    set_rd(1'b1, 5'd1, 1'b1, 5'd2);
    #2 check("wrap_ffff", {16'h0, wr_count}, 32'h0000FFFF);
    check("wrap_r1", rd1_data, 32'h0000FFFE);
    set_wr(1'b1, 5'd4, 32'hCAFEF00D);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    #2 check("wrap_zero", {16'h0, wr_count}, 32'h0);

    // Mid-run reset with a write presented in the reset cycle
    rst = 1'b1;
    set_wr(1'b1, 5'd12, 32'h0BADF00D);
    set_rd(1'b1, 5'd12, 1'b1, 5'd4);
    #2 check("mid_rst_rd1", rd1_data, 32'h0);
    step();
    rst = 1'b0;
    set_wr(1'b0, 5'd0, 32'h0);
    for (int r = 0; r < 32; r++) begin
      set_rd(1'b1, 5'(r), 1'b1, 5'(31 - r));
      #2 check("post_rst_rd1", rd1_data, 32'h0);
      check("post_rst_rd2", rd2_data, 32'h0);
      step();
    end
    check("post_rst_wr_count", {16'h0, wr_count}, 32'h0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_wb_regfile
`default_nettype wire
